// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared constants, sample record and bit-reverse helper for the
//             32-point FFT output reorder path.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int DW  = 16;             // I/Q sample width
  localparam int NPT = 32;             // points per frame (power of two)
  localparam int AW  = $clog2(NPT);    // bin index width

  // One complex bin as stored in the ping-pong RAM.
  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } sample_t;

  // Mirror the bits of a bin index (FFT cores emit bins in this order).
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) begin
      r[b] = a[AW-1-b];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_out_reorder_if
//  Brief    : FFT xk input stream plus reordered valid/ready output stream.
//             master = source/sink side, slave = reorder block.
//  Revision : 1.0 - initial release
// ============================================================================
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic          in_valid;
  logic [DW-1:0] in_i;
  logic [DW-1:0] in_q;
  logic [AW-1:0] in_index;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_i;
  logic [DW-1:0] out_q;
  logic [AW-1:0] out_index;
  logic          out_sof;
  logic          out_eof;
  logic          ovf;

  modport master (
    output in_valid, in_i, in_q, in_index, out_ready,
    input  out_valid, out_i, out_q, out_index, out_sof, out_eof, ovf
  );

  modport slave (
    input  in_valid, in_i, in_q, in_index, out_ready,
    output out_valid, out_i, out_q, out_index, out_sof, out_eof, ovf
  );

endinterface
`default_nettype wire

// File: rtl/fft_pp_bank.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pp_bank
//  Brief    : Two-bank register-file RAM, one write port and one
//             asynchronous read port, each with its own bank select.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_pp_bank
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  sample_t       wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output sample_t       rdata_o
);

  sample_t mem_q [2][NPT];

  // Write port; contents carry no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  // Read is combinational: a same-edge write is not visible, so reads see old data.
  assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_out_reorder
//  Brief    : Double-buffers 32-bin FFT frames and replays them in natural
//             bin order on a valid/ready stream with sof/eof markers.
//             Frames arriving with no free bank are dropped whole (ovf).
//  Revision : 1.0 - initial release
// ============================================================================
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter bit BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  fft_out_reorder_if.slave  bus
);

  localparam logic [AW-1:0] C_LAST_IDX = AW'(NPT - 1);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic          drop_q, drop_d;
  logic          out_valid_q, out_valid_d;
  sample_t       odata_q, odata_d;
  logic          ovf_q, ovf_d;

  logic          xfer, rel, wr_free, store, frame_end, load;
  logic          rbank;
  logic [AW-1:0] raddr, waddr;
  sample_t       wdata, rdata;

  // Handshake and bank-availability decode; a bank released this cycle counts as free.
  assign xfer      = out_valid_q & bus.out_ready;
  assign rel       = xfer & (rcnt_q == C_LAST_IDX);
  assign wr_free   = ~full_q[wr_bank_q] | (rel & (rd_bank_q == wr_bank_q));
  assign store     = bus.in_valid & ((wcnt_q == '0) ? wr_free : ~drop_q);
  assign frame_end = store & (wcnt_q == C_LAST_IDX);

  assign wdata.i = bus.in_i;
  assign wdata.q = bus.in_q;

  if (BITREV) begin : g_bitrev_addr
    assign waddr = bitrev(bus.in_index);
  end else begin : g_natural_addr
    assign waddr = bus.in_index;
  end

  // Pick the entry that must be presented after the coming edge.
  always_comb begin
    rbank = rd_bank_q;
    raddr = rcnt_q;
    if (rel) begin
      rbank = ~rd_bank_q;
      raddr = '0;
    end else if (xfer) begin
      raddr = rcnt_q + AW'(1);
    end
  end

  fft_pp_bank u_bank (
    .clk     (clk),
    .we_i    (store),
    .wbank_i (wr_bank_q),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rbank_i (rbank),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Next-state logic for write admission, bank flags and the output register.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    odata_d     = odata_q;
    ovf_d       = 1'b0;
    load        = 1'b0;

    // Admission is decided once per frame, on its first sample.
    if (bus.in_valid) begin
      wcnt_d = wcnt_q + AW'(1);
      if (wcnt_q == '0) begin
        drop_d = ~wr_free;
        ovf_d  = ~wr_free;
      end
    end

    // Clear before set: a bank is never released and completed in one cycle.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (frame_end) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    // Output side: refill the register whenever it is empty or just consumed.
    if (rel) begin
      rd_bank_d = ~rd_bank_q;
      rcnt_d    = '0;
      load      = full_q[~rd_bank_q];
    end else if (xfer) begin
      rcnt_d = rcnt_q + AW'(1);
      load   = 1'b1;
    end else if (!out_valid_q) begin
      load = full_q[rd_bank_q];
    end

    if (xfer || !out_valid_q) begin
      out_valid_d = load;
    end
    if (load) begin
      odata_d = rdata;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      odata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      odata_q     <= odata_d;
      ovf_q       <= ovf_d;
    end
  end

  // rcnt_q always names the entry held in the output register.
  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = odata_q.i;
  assign bus.out_q     = odata_q.q;
  assign bus.out_index = rcnt_q;
  assign bus.out_sof   = out_valid_q & (rcnt_q == '0);
  assign bus.out_eof   = out_valid_q & (rcnt_q == C_LAST_IDX);
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sits downstream of the 32-point FFT wrapper and consumes its xk stream: y_i, y_q, y_index, one bin per clock, no back-pressure possible.
- Double-buffers complete 32-bin frames and re-issues them in natural bin order (0..31).
- Output is a valid/ready stream with frame markers for the demapper/equaliser stage.
- Frames arriving while both buffers are occupied are dropped whole and flagged.

Parameters:
- DW, 16, bit width of I and Q samples.
- NPT, 32, points per frame (power of two).
- AW, 5, index width, log2(NPT).
- BITREV, 1, 1: write address is bit-reverse(in_index); 0: write address is in_index.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  FFT output sample valid
- in_i  in  DW  FFT output real part
- in_q  in  DW  FFT output imaginary part
- in_index  in  AW  FFT output bin index (xk_index)
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample
- out_i  out  DW  reordered real part
- out_q  out  DW  reordered imaginary part
- out_index  out  AW  natural-order bin number
- out_sof  out  1  high with bin 0 of a frame
- out_eof  out  1  high with bin NPT-1 of a frame
- ovf  out  1  one-cycle pulse: incoming frame dropped

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; both banks empty; wcnt=0; rd_bank=0, wr_bank=0; rcnt=0. RAM contents are not reset.
- Storage: two banks of NPT x (2*DW), each with a full flag.
- Write side:
  - wcnt counts accepted in_valid cycles 0..NPT-1 and wraps.
  - At wcnt==0 with in_valid=1, the frame is admitted if the bank at wr_bank is free.
  - "Free" = full flag clear, or being released in this same cycle (bypass).
  - If not free: frame dropped, ovf=1 for that one cycle, and the next NPT samples are counted but not stored.
  - Admitted samples write {in_i,in_q} at address BITREV ? bitrev(in_index) : in_index.
  - When wcnt==NPT-1 is written: set the bank's full flag, toggle wr_bank, wcnt returns to 0.
  - in_valid gaps inside a frame pause wcnt; they do not abort the frame.
- Read side:
  - When bank rd_bank is full and no output is pending, the next edge loads out_* from entry rcnt and sets out_valid=1.
  - Latency: first out_valid is high 1 cycle after the edge that writes bin NPT-1.
  - Handshake: a transfer occurs when out_valid && out_ready. out_* stay stable while out_valid && !out_ready.
  - After a transfer, the next entry loads on the same edge, giving a gapless stream at full throughput.
  - out_index=rcnt. out_sof=(rcnt==0). out_eof=(rcnt==NPT-1).
  - The transfer of entry NPT-1 clears that bank's full flag, toggles rd_bank and resets rcnt=0.
  - If the other bank is already full, its bin 0 follows on the next cycle with no bubble.
- Simultaneous events:
  - Release and admit of the same bank in one cycle: admit succeeds and ovf=0.
  - Reading entry NPT-1 while writing bin 0 to the same bank: the read returns old data.
- Reset mid-frame: the partial frame is discarded and out_valid drops immediately.
- No arithmetic; data passes bit-exact.

Decomposition:
- Shared package fft_pkg: DW, NPT, AW constants; bitrev function; sample record {i,q}.
- One sub-module: fft_pp_bank, a dual-bank register-file RAM with one write port and one read port and bank select. Flags and counters stay in the top.

Test Plan:
- Reset, then one frame in_index=0..31 with BITREV=0 and in_i=index, in_q=-index, out_ready=1 -> 32 gapless outputs starting 1 cycle after the last input; out_index=0..31; sof on 0; eof on 31; ovf=0.
- BITREV=1, in_index=0..31, in_i=bitrev(index) -> out_i equals 0..31 in order.
- Three back-to-back frames with out_ready=0 -> frames 1 and 2 stored; ovf pulses once at frame 3 bin 0; after out_ready=1, 64 outputs from frames 1 and 2 only.
- out_ready toggling 1,0,0,1 during a frame -> out_* held while stalled; no sample lost or duplicated; 32 transfers total.
- Second frame starts in the same cycle its bank releases (eof transfer) -> admitted, ovf=0, second frame output intact.
- reset asserted at wcnt=17 -> outputs 0 immediately; next full frame comes out correctly from bin 0.
